// File: rtl/serial_rx_pkg.sv
// Shared types and default parameters for the serial word receiver.
package serial_rx_pkg;
    typedef enum logic {HUNT, LOCKED} rx_state_t;

    localparam int         RX_WORD_SIZE    = 27;
    localparam int         RX_SYNC_WIDTH   = 8;
    localparam logic [7:0] RX_SYNC_PATTERN = 8'hA5;
    localparam int         RX_MAX_MISSES   = 2;
endpackage

// File: rtl/rx_word_buffer.sv
// One-entry valid/ready output register; a word arriving while the entry is
// held and not being taken is dropped and flagged with a one-cycle overflow.
module rx_word_buffer #(
    parameter int W = 27
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         overflow_o
);
    logic [W-1:0] data_q;
    logic         valid_q;
    logic         overflow_q;
    logic         room;

    // The entry is free if empty or being handed off on this same edge.
    assign room = !valid_q || ready_i;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= load_i && !room;
            if (load_i && room) begin
                data_q  <= data_i;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = overflow_q;
endmodule

// File: rtl/serial_word_receiver.sv
// MSB-first serial deserializer: hunts for the sync header, tracks word
// alignment and lock, and hands good words to a one-entry output buffer.
module serial_word_receiver
    import serial_rx_pkg::*;
#(
    parameter int                    WORD_SIZE    = RX_WORD_SIZE,
    parameter int                    SYNC_WIDTH   = RX_SYNC_WIDTH,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = SYNC_WIDTH'(RX_SYNC_PATTERN),
    parameter int                    MAX_MISSES   = RX_MAX_MISSES
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 serial_in,
    output logic [WORD_SIZE-1:0] word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 locked,
    output logic                 sync_error,
    output logic                 overflow
);
    localparam int CNT_W  = $clog2(WORD_SIZE);
    localparam int MISS_W = $clog2(MAX_MISSES + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_SIZE - 1);
    localparam logic [CNT_W-1:0]  HDR_BITS = CNT_W'(SYNC_WIDTH);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISSES);

    rx_state_t            state_q;
    logic [WORD_SIZE-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [MISS_W-1:0]    miss_cnt_q;
    logic                 locked_q;
    logic                 sync_error_q;
    logic                 hdr_seen;
    logic                 word_done;
    logic                 hdr_ok;
    logic                 last_miss;

    assign sr_d      = {sr_q[WORD_SIZE-2:0], serial_in};
    assign hdr_seen  = sr_d[SYNC_WIDTH-1:0] == SYNC_PATTERN;
    assign word_done = (state_q == LOCKED) && (bit_cnt_q == LAST_BIT);
    assign hdr_ok    = sr_d[WORD_SIZE-1 -: SYNC_WIDTH] == SYNC_PATTERN;
    assign last_miss = MISS_W'(miss_cnt_q + 1'b1) == MISS_MAX;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= HUNT;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            locked_q     <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            sync_error_q <= 1'b0;
            if (state_q == HUNT) begin
                if (hdr_seen) begin
                    state_q    <= LOCKED;
                    locked_q   <= 1'b1;
                    bit_cnt_q  <= HDR_BITS;
                    miss_cnt_q <= '0;
                end
            end else if (!word_done) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end else begin
                bit_cnt_q <= '0;
                if (hdr_ok) begin
                    miss_cnt_q <= '0;
                end else begin
                    sync_error_q <= 1'b1;
                    if (last_miss) begin
                        miss_cnt_q <= '0;
                        // Drop to hunt, but a header already sitting in the
                        // freshly shifted bits re-locks without losing a cycle.
                        if (hdr_seen) begin
                            bit_cnt_q <= HDR_BITS;
                        end else begin
                            state_q  <= HUNT;
                            locked_q <= 1'b0;
                        end
                    end else begin
                        miss_cnt_q <= miss_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    rx_word_buffer #(.W(WORD_SIZE)) u_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (word_done && hdr_ok),
        .data_i     (sr_d),
        .ready_i    (word_ready),
        .data_o     (word_out),
        .valid_o    (word_valid),
        .overflow_o (overflow)
    );

    assign locked     = locked_q;
    assign sync_error = sync_error_q;
endmodule
